key_cmd_decoder: RTL and testbench

KEY_CMD_DECODER -- requirements
Module: key_cmd_decoder

---
 rtl/key_cmd_decoder.sv | 192 +++++++++++++++++++
 tb/tb_key_cmd_decoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/key_cmd_decoder.sv
// PS/2 set-2 scan-code decoder for paddle game controls: prefix FSM, held-key
// flags with stuck-key watchdogs, start edge pulse and pause toggle.
module key_cmd_decoder #(
    parameter logic [7:0]  KEY_UP       = 8'h1D,
    parameter logic [7:0]  KEY_DOWN     = 8'h1B,
    parameter logic [7:0]  KEY_START    = 8'h29,
    parameter logic [7:0]  KEY_PAUSE    = 8'h4D,
    parameter int unsigned HOLD_TIMEOUT = 100_000_000
) (
    input  logic       CLK100MHZ,
    input  logic       RST,
    input  logic [7:0] SCAN_CODE,
    input  logic       SCAN_VALID,
    output logic       MOVE_UP,
    output logic       MOVE_DOWN,
    output logic       START_PULSE,
    output logic       PAUSED,
    output logic [7:0] LAST_KEY
);

    localparam logic [7:0] CODE_BRK     = 8'hF0;
    localparam logic [7:0] CODE_EXT     = 8'hE0;
    localparam logic [7:0] EXT_UP_ARROW = 8'h75;
    localparam logic [7:0] EXT_DN_ARROW = 8'h72;
    localparam int         CNT_W        = $clog2(HOLD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    state_t     state_q, state_d;
    logic       start_held_q, start_held_d;
    logic       pause_held_q, pause_held_d;
    logic       paused_q, paused_d;
    logic       start_pulse_q, start_pulse_d;
    logic       move_up_q, move_up_d;
    logic       move_down_q, move_down_d;
    logic [7:0] last_key_q, last_key_d;

    logic       is_ext, is_brk, byte_final, key_ok;
    logic [7:0] key;
    logic       make_ev, brk_ev;
    logic [1:0] mv_make, mv_brk, mv_held_d;

    // Decode the byte that terminates a sequence; extended arrows alias the
    // paddle keys, every other extended code is dropped.
    always_comb begin
        is_ext     = (state_q == EXT) || (state_q == EXT_BRK);
        is_brk     = (state_q == BRK) || (state_q == EXT_BRK);
        byte_final = SCAN_VALID && (SCAN_CODE != CODE_BRK) && (SCAN_CODE != CODE_EXT);
        key        = SCAN_CODE;
        key_ok     = 1'b1;
        if (is_ext) begin
            if (SCAN_CODE == EXT_UP_ARROW) begin
                key = KEY_UP;
            end else if (SCAN_CODE == EXT_DN_ARROW) begin
                key = KEY_DOWN;
            end else begin
                key_ok = 1'b0;
            end
        end
        make_ev    = byte_final && key_ok && !is_brk;
        brk_ev     = byte_final && key_ok && is_brk;
        mv_make[0] = make_ev && (key == KEY_UP);
        mv_make[1] = make_ev && (key == KEY_DOWN);
        mv_brk[0]  = brk_ev && (key == KEY_UP);
        mv_brk[1]  = brk_ev && (key == KEY_DOWN);
    end

    always_comb begin
        state_d = state_q;
        if (SCAN_VALID) begin
            case (state_q)
                IDLE: begin
                    if (SCAN_CODE == CODE_BRK)      state_d = BRK;
                    else if (SCAN_CODE == CODE_EXT) state_d = EXT;
                    else                            state_d = IDLE;
                end
                EXT: begin
                    if (SCAN_CODE == CODE_BRK)      state_d = EXT_BRK;
                    else if (SCAN_CODE == CODE_EXT) state_d = EXT;
                    else                            state_d = IDLE;
                end
                BRK: begin
                    if (SCAN_CODE == CODE_BRK)      state_d = BRK;
                    else if (SCAN_CODE == CODE_EXT) state_d = EXT_BRK;
                    else                            state_d = IDLE;
                end
                default: begin
                    if ((SCAN_CODE == CODE_BRK) || (SCAN_CODE == CODE_EXT)) state_d = EXT_BRK;
                    else                                                    state_d = IDLE;
                end
            endcase
        end
    end

    // Up/down watchdogs: reload on make, count only while held, and force a
    // release after HOLD_TIMEOUT cycles in case the break byte was lost.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wdog
            logic             held_q, held_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                held_d = held_q;
                cnt_d  = cnt_q;
                if (mv_make[gi]) begin
                    held_d = 1'b1;
                    cnt_d  = '0;
                end else if (mv_brk[gi]) begin
                    held_d = 1'b0;
                    cnt_d  = '0;
                end else if (held_q) begin
                    if (cnt_q >= CNT_LAST) begin
                        held_d = 1'b0;
                        cnt_d  = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge CLK100MHZ or negedge RST) begin
                if (!RST) begin
                    held_q <= 1'b0;
                    cnt_q  <= '0;
                end else begin
                    held_q <= held_d;
                    cnt_q  <= cnt_d;
                end
            end

            assign mv_held_d[gi] = held_d;
        end
    endgenerate

    always_comb begin
        start_held_d  = start_held_q;
        pause_held_d  = pause_held_q;
        paused_d      = paused_q;
        start_pulse_d = 1'b0;
        last_key_d    = last_key_q;
        if (make_ev && !is_ext) begin
            last_key_d = SCAN_CODE;
        end
        if (make_ev && (key == KEY_START)) begin
            start_pulse_d = !start_held_q;
            start_held_d  = 1'b1;
        end else if (brk_ev && (key == KEY_START)) begin
            start_held_d = 1'b0;
        end
        if (make_ev && (key == KEY_PAUSE)) begin
            paused_d     = paused_q ^ !pause_held_q;
            pause_held_d = 1'b1;
        end else if (brk_ev && (key == KEY_PAUSE)) begin
            pause_held_d = 1'b0;
        end
        // Outputs are built from next-state flags so they show one cycle after the byte.
        move_up_d   = mv_held_d[0] && !mv_held_d[1] && !paused_d;
        move_down_d = mv_held_d[1] && !mv_held_d[0] && !paused_d;
    end

    always_ff @(posedge CLK100MHZ or negedge RST) begin
        if (!RST) begin
            state_q       <= IDLE;
            start_held_q  <= 1'b0;
            pause_held_q  <= 1'b0;
            paused_q      <= 1'b0;
            start_pulse_q <= 1'b0;
            move_up_q     <= 1'b0;
            move_down_q   <= 1'b0;
            last_key_q    <= 8'h00;
        end else begin
            state_q       <= state_d;
            start_held_q  <= start_held_d;
            pause_held_q  <= pause_held_d;
            paused_q      <= paused_d;
            start_pulse_q <= start_pulse_d;
            move_up_q     <= move_up_d;
            move_down_q   <= move_down_d;
            last_key_q    <= last_key_d;
        end
    end

    assign MOVE_UP     = move_up_q;
    assign MOVE_DOWN   = move_down_q;
    assign START_PULSE = start_pulse_q;
    assign PAUSED      = paused_q;
    assign LAST_KEY    = last_key_q;

endmodule

// File: tb/tb_key_cmd_decoder.sv
// Directed bench for key_cmd_decoder: drives scan bytes on the falling edge and
// checks registered outputs at the following falling edge.
module tb_key_cmd_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       move_up, move_down, start_pulse, paused;
    logic [7:0] last_key;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    int pulse_base;

    always #5 clk = ~clk;

    key_cmd_decoder #(
        .HOLD_TIMEOUT(100)
    ) dut (
        .CLK100MHZ  (clk),
        .RST        (rst_n),
        .SCAN_CODE  (scan_code),
        .SCAN_VALID (scan_valid),
        .MOVE_UP    (move_up),
        .MOVE_DOWN  (move_down),
        .START_PULSE(start_pulse),
        .PAUSED     (paused),
        .LAST_KEY   (last_key)
    );

    always @(negedge clk) begin
        if (start_pulse) pulse_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Byte is presented for one cycle; returns on the falling edge after the capturing edge.
    task automatic send_byte(input logic [7:0] b);
        scan_code  = b;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
        $display("tx %02h -> up=%0b dn=%0b st=%0b ps=%0b last=%02h",
                 b, move_up, move_down, start_pulse, paused, last_key);
    endtask

    task automatic send_burst(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        scan_valid = 1'b1;
        scan_code  = b0;
        @(negedge clk);
        scan_code  = b1;
        @(negedge clk);
        scan_code  = b2;
        @(negedge clk);
        scan_valid = 1'b0;
        $display("tx burst %02h %02h %02h -> up=%0b dn=%0b last=%02h",
                 b0, b1, b2, move_up, move_down, last_key);
    endtask

    initial begin
        rst_n      = 1'b0;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_move_up", move_up, 0);
        check_eq("rst_move_down", move_down, 0);
        check_eq("rst_start", start_pulse, 0);
        check_eq("rst_paused", paused, 0);
        check_eq("rst_last_key", last_key, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic make / break of the up key
        send_byte(8'h1D);
        check_eq("make_up", move_up, 1);
        check_eq("make_up_last", last_key, 8'h1D);
        send_byte(8'hF0);
        check_eq("brk_prefix_hold", move_up, 1);
        send_byte(8'h1D);
        check_eq("brk_up", move_up, 0);

        // Extended arrows and opposing keys
        send_byte(8'hE0);
        send_byte(8'h75);
        check_eq("ext_up", move_up, 1);
        check_eq("ext_no_last", last_key, 8'h1D);
        send_byte(8'h1B);
        check_eq("opp_up", move_up, 0);
        check_eq("opp_down", move_down, 0);
        check_eq("opp_last", last_key, 8'h1B);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        check_eq("ext_brk_down", move_down, 1);
        check_eq("ext_brk_up", move_up, 0);
        send_byte(8'hE0);
        send_byte(8'h11);
        check_eq("ext_unmapped_last", last_key, 8'h1B);
        check_eq("ext_unmapped_down", move_down, 1);
        send_byte(8'hF0);
        send_byte(8'h1B);
        check_eq("brk_down", move_down, 0);

        // Start pulses with typematic repeats
        pulse_base = pulse_cnt;
        send_byte(8'h29);
        check_eq("start_first", start_pulse, 1);
        send_byte(8'h29);
        check_eq("start_repeat", start_pulse, 0);
        send_byte(8'h29);
        send_byte(8'hF0);
        send_byte(8'h29);
        check_eq("start_brk", start_pulse, 0);
        send_byte(8'h29);
        check_eq("start_again", start_pulse, 1);
        @(negedge clk);
        @(negedge clk);
        check_eq("start_total", pulse_cnt - pulse_base, 2);
        send_byte(8'hF0);
        send_byte(8'h29);

        // Pause toggling with up held
        send_byte(8'h1D);
        send_byte(8'h4D);
        send_byte(8'hF0);
        send_byte(8'h4D);
        check_eq("pause_on", paused, 1);
        check_eq("pause_blocks_up", move_up, 0);
        check_eq("pause_last", last_key, 8'h4D);
        send_byte(8'h4D);
        send_byte(8'h4D);
        check_eq("pause_repeat", paused, 0);
        check_eq("pause_resume_up", move_up, 1);
        send_byte(8'hF0);
        send_byte(8'h4D);
        send_byte(8'h4D);
        check_eq("pause_on2", paused, 1);
        send_byte(8'hF0);
        send_byte(8'h4D);
        send_byte(8'h4D);
        send_byte(8'hF0);
        send_byte(8'h4D);
        check_eq("pause_off2", paused, 0);
        check_eq("pause_off2_up", move_up, 1);
        send_byte(8'hF0);
        send_byte(8'h1D);
        check_eq("pause_rel_up", move_up, 0);

        // Back-to-back bytes with valid held high
        send_burst(8'hE0, 8'h72, 8'h00);
        check_eq("burst_down", move_down, 1);
        check_eq("burst_last", last_key, 8'h00);
        send_burst(8'hF0, 8'h1B, 8'h1D);
        check_eq("burst_down_rel", move_down, 0);
        check_eq("burst_up", move_up, 1);
        send_byte(8'hF0);
        send_byte(8'h1D);

        // Stuck-key watchdog
        send_byte(8'h1D);
        check_eq("wd_set", move_up, 1);
        repeat (98) @(negedge clk);
        check_eq("wd_before", move_up, 1);
        repeat (4) @(negedge clk);
        check_eq("wd_cleared", move_up, 0);
        send_byte(8'h1D);
        for (int i = 0; i < 5; i++) begin
            repeat (49) @(negedge clk);
            check_eq("wd_reload", move_up, 1);
            send_byte(8'h1D);
        end
        send_byte(8'hF0);
        send_byte(8'h1D);
        check_eq("wd_rel", move_up, 0);

        // Reset in the middle of an extended sequence
        send_byte(8'h4D);
        check_eq("pre_rst_paused", paused, 1);
        send_byte(8'hE0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("mid_rst_paused", paused, 0);
        check_eq("mid_rst_last", last_key, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h75);
        check_eq("post_rst_75_up", move_up, 0);
        check_eq("post_rst_75_last", last_key, 8'h75);
        send_byte(8'h1D);
        check_eq("post_rst_up", move_up, 1);
        check_eq("post_rst_paused", paused, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
